fft_band_analyzer: RTL and testbench

Downstream consumer of the FFT magnitude stream: collects the 256 positive-frequency magnitude bins of each frame and sums them into NUM_BANDS equal-width bands. It also tracks the non-DC peak bin. At frame end it drains one averaged level per band over a valid/ready handshake to the display/UART stage. It sits between the FFT core output port and the spectrum presentation logic.

---
 rtl/fft_band_analyzer.sv | 188 ++++++++++++++++++
 tb/tb_fft_band_analyzer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_band_analyzer.sv
// -----------------------------------------------------------------------------
// fft_band_analyzer
//
// Collects the 256 positive-frequency magnitude bins of each FFT frame and
// sums them into NUM_BANDS equal-width bands. It also tracks the largest
// non-DC bin. On the end-of-frame strobe it drains one averaged level per band,
// in band order, over a valid/ready handshake.
//
// Optional feature macro: FFT_BAND_PEAK_HOLD_EN
//   When defined, each band keeps a held level. On every transfer the held
//   value becomes max(avg, held - (held >> DECAY_SHIFT)), and that is the
//   value presented on o_band_level. When undefined, the raw average is
//   presented and no held registers exist.
//
// Ports
//   clk                   system clock
//   reset                 synchronous, active-low reset
//   i_fft_magnitude_addr  bin index of the current magnitude (0..511)
//   i_fft_magnitude_out   unsigned magnitude
//   i_fft_out_valid       qualifies addr/magnitude
//   i_fft_done_pulse      one-cycle end-of-frame strobe
//   o_band_idx            index of the band being presented
//   o_band_level          averaged (or held) level of that band
//   o_band_valid          band output valid
//   i_band_ready          downstream accepts the band
//   o_peak_bin            bin of the largest magnitude, searched over 1..255
//   o_peak_mag            magnitude at o_peak_bin
//   o_frame_done          one-cycle pulse after the last band transfer
//   o_busy                high while draining
//   o_overrun             sticky: input arrived while draining
// -----------------------------------------------------------------------------
module fft_band_analyzer #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 9,
  parameter int NUM_BANDS   = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            i_fft_magnitude_addr,
  input  logic [DATA_W-1:0]            i_fft_magnitude_out,
  input  logic                         i_fft_out_valid,
  input  logic                         i_fft_done_pulse,
  output logic [$clog2(NUM_BANDS)-1:0] o_band_idx,
  output logic [DATA_W-1:0]            o_band_level,
  output logic                         o_band_valid,
  input  logic                         i_band_ready,
  output logic [7:0]                   o_peak_bin,
  output logic [DATA_W-1:0]            o_peak_mag,
  output logic                         o_frame_done,
  output logic                         o_busy,
  output logic                         o_overrun
);

  localparam int BAND_W = $clog2(NUM_BANDS);
  // Each band spans 2^SHIFT bins; the average is a plain right shift.
  localparam int SHIFT  = 8 - BAND_W;
  // Wide enough to sum 2^SHIFT full-scale magnitudes without overflow.
  localparam int ACC_W  = DATA_W + SHIFT;

  typedef enum logic {
    ACCUM,
    DRAIN
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc [NUM_BANDS];
  logic [7:0]        cand_bin;
  logic [DATA_W-1:0] cand_mag;

  // Only the lower half of the 512-point spectrum is of interest.
  logic              in_lower;
  logic [7:0]        bin;
  logic [BAND_W-1:0] band_sel;
  logic              xfer;
  logic              last_band;

  assign in_lower  = i_fft_out_valid && (i_fft_magnitude_addr[ADDR_W-1:8] == '0);
  assign bin       = i_fft_magnitude_addr[7:0];
  assign band_sel  = i_fft_magnitude_addr[7:SHIFT];
  assign xfer      = o_band_valid && i_band_ready;
  assign last_band = (o_band_idx == BAND_W'(NUM_BANDS - 1));

  // Candidate including the current sample, so a sample arriving with the
  // done strobe still takes part in the peak search. Bin 0 (DC) is skipped,
  // and only a strictly larger magnitude replaces it, so the lowest bin wins
  // ties.
  logic [7:0]        nxt_bin;
  logic [DATA_W-1:0] nxt_mag;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves it unassigned would infer a latch.
    nxt_bin = cand_bin;
    nxt_mag = cand_mag;
    if (in_lower && (bin != 8'd0) && (i_fft_magnitude_out > cand_mag)) begin
      nxt_bin = bin;
      nxt_mag = i_fft_magnitude_out;
    end
  end

  // Average of the band currently presented; stays stable while stalled
  // because accumulators are frozen during the drain.
  logic [DATA_W-1:0] avg;
  logic [DATA_W-1:0] present;

  assign avg = acc[o_band_idx][ACC_W-1:SHIFT];

`ifdef FFT_BAND_PEAK_HOLD_EN
  logic [DATA_W-1:0] held [NUM_BANDS];
  logic [DATA_W-1:0] decayed;

  assign decayed = held[o_band_idx] - (held[o_band_idx] >> DECAY_SHIFT);
  assign present = (avg > decayed) ? avg : decayed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANDS; b++) held[b] <= '0;
    end else if (state == DRAIN && xfer) begin
      held[o_band_idx] <= present;
    end
  end
`else
  logic unused_decay;
  assign unused_decay = (DECAY_SHIFT != 0);
  assign present      = avg;
`endif

  assign o_band_level = o_band_valid ? present : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ACCUM;
      o_band_idx   <= '0;
      o_band_valid <= 1'b0;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
      cand_bin     <= '0;
      cand_mag     <= '0;
      // NOTE: the accumulator array is small and must start each frame at
      // zero, so it is cleared by reset rather than left to a RAM.
      for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values of the others.
      o_frame_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (in_lower) begin
            acc[band_sel] <= acc[band_sel] + ACC_W'(i_fft_magnitude_out);
          end
          if (i_fft_done_pulse) begin
            o_peak_bin   <= nxt_bin;
            o_peak_mag   <= nxt_mag;
            cand_bin     <= '0;
            cand_mag     <= '0;
            o_band_idx   <= '0;
            o_band_valid <= 1'b1;
            o_busy       <= 1'b1;
            state        <= DRAIN;
          end else begin
            cand_bin <= nxt_bin;
            cand_mag <= nxt_mag;
          end
        end

        DRAIN: begin
          // Anything arriving now is dropped and flagged.
          if (i_fft_out_valid || i_fft_done_pulse) o_overrun <= 1'b1;
          if (xfer) begin
            o_band_idx <= o_band_idx + BAND_W'(1);
            if (last_band) begin
              for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
              o_band_valid <= 1'b0;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
              state        <= ACCUM;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_band_analyzer.sv
// -----------------------------------------------------------------------------
// tb_fft_band_analyzer
//
// Self-checking bench for fft_band_analyzer. Frames are described as a plain
// array of 256 magnitudes; the expected band sums, averages, held levels and
// peak come straight from that array. A single compare process checks every
// output on every falling edge against that model, and directed tests add
// literal expectations taken from hand arithmetic.
// -----------------------------------------------------------------------------
module tb_fft_band_analyzer;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 9;
  localparam int NB     = 8;
  localparam int DS     = 3;
  localparam int SH     = 5;   // bins per band = 32

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] i_fft_magnitude_addr = '0;
  logic [DATA_W-1:0] i_fft_magnitude_out = '0;
  logic              i_fft_out_valid = 1'b0;
  logic              i_fft_done_pulse = 1'b0;
  logic [2:0]        o_band_idx;
  logic [DATA_W-1:0] o_band_level;
  logic              o_band_valid;
  logic              i_band_ready = 1'b0;
  logic [7:0]        o_peak_bin;
  logic [DATA_W-1:0] o_peak_mag;
  logic              o_frame_done;
  logic              o_busy;
  logic              o_overrun;

  fft_band_analyzer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANDS(NB), .DECAY_SHIFT(DS)
  ) dut (
    .clk(clk), .reset(reset),
    .i_fft_magnitude_addr(i_fft_magnitude_addr),
    .i_fft_magnitude_out(i_fft_magnitude_out),
    .i_fft_out_valid(i_fft_out_valid),
    .i_fft_done_pulse(i_fft_done_pulse),
    .o_band_idx(o_band_idx), .o_band_level(o_band_level),
    .o_band_valid(o_band_valid), .i_band_ready(i_band_ready),
    .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint frame[256];          // magnitudes of the frame being sent
  longint m_sum[NB];           // band sums of that frame
  int     m_pbin;
  longint m_pmag;

  bit     pend_drain = 0, pend_ovr = 0;
  longint pend_sum[NB];
  int     pend_pbin = 0;
  longint pend_pmag = 0;

  bit     exp_draining = 0, exp_ovr = 0, exp_done_next = 0;
  int     exp_idx = 0;
  longint exp_lvl[NB];
  longint held[NB];
  int     exp_pbin = 0;
  longint exp_pmag = 0;

  task automatic model_frame();
    for (int b = 0; b < NB; b++) m_sum[b] = 0;
    m_pbin = 0;
    m_pmag = 0;
    for (int i = 0; i < 256; i++) begin
      m_sum[i / 32] += frame[i];
      if (i > 0 && frame[i] > m_pmag) begin
        m_pmag = frame[i];
        m_pbin = i;
      end
    end
  endtask

  // Called at the moment the done strobe is driven.
  task automatic raise_done();
    i_fft_done_pulse = 1'b1;
    for (int b = 0; b < NB; b++) pend_sum[b] = m_sum[b];
    pend_pbin  = m_pbin;
    pend_pmag  = m_pmag;
    pend_drain = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      exp_draining = 0; exp_ovr = 0; exp_done_next = 0; exp_idx = 0;
      exp_pbin = 0; exp_pmag = 0; pend_drain = 0; pend_ovr = 0;
      for (int b = 0; b < NB; b++) held[b] = 0;
    end else begin
      check("frame_done", o_frame_done, exp_done_next);
      exp_done_next = 0;
      check("busy", o_busy, exp_draining);
      check("band_valid", o_band_valid, exp_draining);
      if (exp_draining) begin
        check("band_idx", o_band_idx, exp_idx);
        check("band_level", o_band_level, exp_lvl[exp_idx]);
        if (i_band_ready) begin
          held[exp_idx] = exp_lvl[exp_idx];
          if (exp_idx == NB - 1) begin
            exp_draining  = 0;
            exp_done_next = 1;
            exp_idx       = 0;
          end else begin
            exp_idx++;
          end
        end
      end
      check("peak_bin", o_peak_bin, exp_pbin);
      check("peak_mag", o_peak_mag, exp_pmag);
      check("overrun", o_overrun, exp_ovr);
      if (pend_ovr) begin
        exp_ovr  = 1;
        pend_ovr = 0;
      end
      if (pend_drain) begin
        pend_drain   = 0;
        exp_draining = 1;
        exp_idx      = 0;
        exp_pbin     = pend_pbin;
        exp_pmag     = pend_pmag;
        for (int b = 0; b < NB; b++) begin
          longint avg, dec;
          avg = pend_sum[b] / 32;
          dec = held[b] - held[b] / 8;
`ifdef FFT_BAND_PEAK_HOLD_EN
          exp_lvl[b] = (avg > dec) ? avg : dec;
`else
          exp_lvl[b] = avg + 0 * dec;
`endif
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < 256; i++) frame[i] = v;
  endtask

  // Sends frame[]; returns one step after the edge that sampled the done strobe.
  task automatic send_frame(input bit noise, input bit hi_fill);
    bit dlast;
    model_frame();
    dlast = noise ? bit'($urandom_range(0, 1)) : 1'b0;
    sync();
    if (hi_fill) begin
      for (int j = 256; j < 512; j++) begin
        i_fft_out_valid      = 1'b1;
        i_fft_magnitude_addr = ADDR_W'(j);
        i_fft_magnitude_out  = 24'hFFFFFF;
        sync();
      end
    end
    for (int i = 0; i < 256; i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 1)) begin
          i_fft_out_valid = 1'b0;
          sync();
        end
        if ($urandom_range(0, 7) == 0) begin
          i_fft_out_valid      = 1'b1;
          i_fft_magnitude_addr = ADDR_W'(256 + $urandom_range(0, 255));
          i_fft_magnitude_out  = DATA_W'($urandom);
          sync();
        end
      end
      i_fft_out_valid      = 1'b1;
      i_fft_magnitude_addr = ADDR_W'(i);
      i_fft_magnitude_out  = DATA_W'(frame[i]);
      if (i == 255 && dlast) raise_done();
      sync();
    end
    i_fft_out_valid  = 1'b0;
    i_fft_done_pulse = 1'b0;
    if (!dlast) begin
      raise_done();
      sync();
      i_fft_done_pulse = 1'b0;
    end
  endtask

  // Runs the drain to o_frame_done; cycles counts edges after the done edge.
  task automatic drain(input bit rnd, input longint lvl0, output int cycles);
    bit seen;
    seen   = 0;
    cycles = 0;
    i_band_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0 && lvl0 >= 0) check("first_level_literal", o_band_level, lvl0);
      if (o_frame_done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      cycles++;
      #1;
      i_band_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    check("drain_completed", seen, 1);
  endtask

  // Caller is one step after a rising edge (or at time zero).
  task automatic do_reset();
    reset = 1'b0;
    i_fft_out_valid  = 1'b0;
    i_fft_done_pulse = 1'b0;
    i_band_ready     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_band_idx", o_band_idx, 0);
    check("rst_band_level", o_band_level, 0);
    check("rst_band_valid", o_band_valid, 0);
    check("rst_peak_bin", o_peak_bin, 0);
    check("rst_peak_mag", o_peak_mag, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    sync();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    do_reset();

    // Constant 1000 on every bin, zero-stall drain.
    fill(1000);
    send_frame(0, 0);
    drain(0, 1000, cyc);
    check("zero_stall_cycles", cyc, NB);

    // Peak at bin 5, DC excluded; band 0 = (9000+5000+30*100)/32 = 531.
    sync(); do_reset();
    fill(100);
    frame[0] = 9000;
    frame[5] = 5000;
    send_frame(0, 0);
    i_band_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      check("stall_idx", o_band_idx, 0);
      check("stall_level", o_band_level, 531);
      sync();
    end
    drain(0, -1, cyc);
    check("stalled_drain_cycles", 10 + cyc, NB + 10);
    check("peak_bin_literal", o_peak_bin, 5);
    check("peak_mag_literal", o_peak_mag, 5000);

    // Upper half full-scale, lower half zero.
    sync(); do_reset();
    fill(0);
    send_frame(0, 1);
    drain(0, 0, cyc);
    check("hi_ignored_peak_bin", o_peak_bin, 0);
    check("hi_ignored_peak_mag", o_peak_mag, 0);

    // Input during drain sets sticky overrun and is discarded.
    sync(); do_reset();
    fill(0);
    send_frame(0, 0);
    i_band_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      i_fft_out_valid      = 1'b1;
      i_fft_magnitude_addr = ADDR_W'($urandom_range(0, 255));
      i_fft_magnitude_out  = DATA_W'($urandom_range(1000, 50000));
      i_fft_done_pulse     = (j == 1);
      if (j == 0) pend_ovr = 1'b1;
      sync();
    end
    i_fft_out_valid  = 1'b0;
    i_fft_done_pulse = 1'b0;
    drain(1, -1, cyc);
    check("overrun_set", o_overrun, 1);
    fill(200);
    send_frame(0, 0);
    drain(1, 200, cyc);
    check("overrun_sticky", o_overrun, 1);

    // Reset in the middle of a drain, at band 3.
    sync(); do_reset();
    fill(777);
    send_frame(0, 0);
    i_band_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    fill(50);
    send_frame(0, 0);
    drain(0, 50, cyc);

    // Done strobe with no samples drains zeros.
    sync();
    fill(0);
    model_frame();
    raise_done();
    sync();
    i_fft_done_pulse = 1'b0;
    drain(0, 0, cyc);

    // Peak hold: all-1000 then all-0.
    sync(); do_reset();
    fill(1000);
    send_frame(0, 0);
    drain(0, 1000, cyc);
    fill(0);
    send_frame(0, 0);
`ifdef FFT_BAND_PEAK_HOLD_EN
    drain(0, 875, cyc);
`else
    drain(0, 0, cyc);
`endif

    // Randomized frames with gaps, stray upper-half samples and random ready.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 256; i++)
        frame[i] = (f % 2 == 0) ? longint'($urandom_range(0, 15))
                                : longint'($urandom & 32'h00FF_FFFF);
      send_frame(1, 0);
      drain(1, -1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
